// File: rtl/al422_frame_writer_if.sv
// ---------------------------------------------------------------------------
// al422_frame_writer_if
//
// Pixel stream between the frame source and the AL422 frame writer.
//   pix_data  : RGB555 word {1'b0, B[4:0], G[4:0], R[4:0]}
//   pix_valid : pix_data holds a pixel
//   pix_ready : writer accepts the pixel on cycles with pix_valid & pix_ready
//
// Modports:
//   master : pixel source (drives pix_data / pix_valid)
//   slave  : frame writer (drives pix_ready)
// ---------------------------------------------------------------------------
interface al422_frame_writer_if;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;

    modport master (
        output pix_data,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        output pix_ready
    );
endinterface

// File: rtl/al422_frame_writer.sv
// ---------------------------------------------------------------------------
// al422_frame_writer
//
// Writes one frame of RGB555 pixels into an AL422 field FIFO, two bytes per
// pixel, low byte first. Each frame starts with a write-pointer reset (WRST,
// with WCK toggling so the AL422 actually sees the reset) and ends with a
// one-cycle frame_done strobe. WCK, /WE and /WRST are all generated from
// in_clk and every output comes straight from a register.
//
// Parameters:
//   FRAME_PIXELS : pixels per frame, 1..65535
//   WRST_CYCLES  : in_clk cycles that fifo_wrst_n is held low, >= 2
//
// Ports:
//   in_clk       : system clock, rising edge
//   in_rst       : synchronous active-high reset
//   frame_start  : one-cycle frame request, honoured only when idle
//   pix          : pixel stream (slave side: pix_data, pix_valid, pix_ready)
//   fifo_data    : AL422 DI[7:0]
//   fifo_wck     : AL422 WCK
//   fifo_we_n    : AL422 /WE
//   fifo_wrst_n  : AL422 /WRST
//   busy         : accepted frame_start .. frame_done
//   frame_done   : one-cycle strobe after the last byte's WCK rising edge
//   underrun     : sticky "a pixel was padded" flag for the current frame
//
// Build option:
//   AL422_WRITER_PAD_EN : when defined, a missing pixel after the first one
//   is replaced by 0x0000 so the frame length in cycles never changes, and
//   underrun is raised. When undefined the writer simply stalls and underrun
//   stays 0.
//
// Byte slot timing (WRITE state): ph=0 presents the byte with WCK low and
// /WE low, ph=1 raises WCK and the AL422 latches on that edge. A pixel is two
// slots; the next pixel is taken in the last cycle of the high-byte slot so
// a continuous stream costs exactly 4 cycles per pixel.
// ---------------------------------------------------------------------------
module al422_frame_writer #(
    parameter int FRAME_PIXELS = 2048,
    parameter int WRST_CYCLES  = 4
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  frame_start,
    al422_frame_writer_if.slave   pix,
    output logic [7:0]            fifo_data,
    output logic                  fifo_wck,
    output logic                  fifo_we_n,
    output logic                  fifo_wrst_n,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  underrun
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRST  = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [15:0] PIX_LOAD  = 16'(FRAME_PIXELS);
    localparam logic [15:0] WRST_LOAD = 16'(WRST_CYCLES - 1);

    // -----------------------------------------------------------------------
    // Registers and their next values
    // -----------------------------------------------------------------------
    logic [2:0]  state_reg,     state_next;
    logic [15:0] pix_left_reg,  pix_left_next;
    logic [15:0] wrst_cnt_reg,  wrst_cnt_next;
    logic [15:0] pix_reg,       pix_next;
    logic        byte_sel_reg,  byte_sel_next;
    logic        ph_reg,        ph_next;

    logic [7:0]  data_reg,      data_next;
    logic        wck_reg,       wck_next;
    logic        we_n_reg,      we_n_next;
    logic        wrst_n_reg,    wrst_n_next;
    logic        busy_reg,      busy_next;
    logic        done_reg,      done_next;
    logic        underrun_reg,  underrun_next;
    logic        ready_reg,     ready_next;

    // Word to start writing this cycle (real pixel or pad word)
    logic        load_en;
    logic [15:0] load_word;
    logic        handshake;

    assign handshake = pix.pix_valid & ready_reg;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        pix_left_next = pix_left_reg;
        wrst_cnt_next = wrst_cnt_reg;
        pix_next      = pix_reg;
        byte_sel_next = byte_sel_reg;
        ph_next       = ph_reg;
        data_next     = data_reg;
        wck_next      = wck_reg;
        we_n_next     = we_n_reg;
        wrst_n_next   = wrst_n_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        underrun_next = underrun_reg;
        ready_next    = ready_reg;
        load_en       = 1'b0;
        load_word     = 16'h0000;

        case (state_reg)
            ST_IDLE: begin
                if (frame_start) begin
                    state_next    = ST_WRST;
                    pix_left_next = PIX_LOAD;
                    wrst_cnt_next = WRST_LOAD;
                    underrun_next = 1'b0;
                    busy_next     = 1'b1;
                    wrst_n_next   = 1'b0;
                    wck_next      = 1'b0;
                    we_n_next     = 1'b1;
                    ready_next    = 1'b0;
                end
            end

            ST_WRST: begin
                // The AL422 only samples /WRST on WCK edges, so keep WCK
                // running for the whole reset window.
                wck_next = ~wck_reg;
                if (wrst_cnt_reg == 16'd0) begin
                    state_next  = ST_FETCH;
                    wrst_n_next = 1'b1;
                    wck_next    = 1'b0;
                    we_n_next   = 1'b1;
                    ready_next  = 1'b1;
                end else begin
                    wrst_cnt_next = wrst_cnt_reg - 16'd1;
                end
            end

            ST_FETCH: begin
                wck_next  = 1'b0;
                we_n_next = 1'b1;
                if (handshake) begin
                    load_en   = 1'b1;
                    load_word = pix.pix_data;
                end
`ifdef AL422_WRITER_PAD_EN
                // Only the first pixel of a frame may wait; any later gap
                // is filled so the frame keeps its nominal length.
                else if (pix_left_reg != PIX_LOAD) begin
                    load_en       = 1'b1;
                    underrun_next = 1'b1;
                end
`endif
            end

            ST_WRITE: begin
                if (!ph_reg) begin
                    // Second half of the slot: rising WCK edge.
                    wck_next = 1'b1;
                    ph_next  = 1'b1;
                    // Open the pixel port for the last cycle of the high
                    // byte so the next word follows without a gap.
                    if (byte_sel_reg) begin
                        ready_next = (pix_left_reg != 16'd0);
                    end
                end else if (!byte_sel_reg) begin
                    // Low byte latched; present the high byte.
                    data_next     = pix_reg[15:8];
                    wck_next      = 1'b0;
                    ph_next       = 1'b0;
                    byte_sel_next = 1'b1;
                end else begin
                    // End of the high-byte slot.
                    wck_next   = 1'b0;
                    ready_next = 1'b0;
                    if (pix_left_reg == 16'd0) begin
                        state_next = ST_DONE;
                        we_n_next  = 1'b1;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                    end else if (handshake) begin
                        load_en   = 1'b1;
                        load_word = pix.pix_data;
                    end
`ifdef AL422_WRITER_PAD_EN
                    else begin
                        load_en       = 1'b1;
                        underrun_next = 1'b1;
                    end
`else
                    else begin
                        state_next = ST_FETCH;
                        we_n_next  = 1'b1;
                        ready_next = 1'b1;
                    end
`endif
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
                we_n_next  = 1'b1;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Common pixel-load action: start the low-byte slot of load_word.
        if (load_en) begin
            state_next    = ST_WRITE;
            pix_next      = load_word;
            pix_left_next = (pix_left_reg != 16'd0) ? (pix_left_reg - 16'd1) : 16'd0;
            byte_sel_next = 1'b0;
            ph_next       = 1'b0;
            data_next     = load_word[7:0];
            wck_next      = 1'b0;
            we_n_next     = 1'b0;
            ready_next    = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_reg    <= ST_IDLE;
            pix_left_reg <= 16'd0;
            wrst_cnt_reg <= 16'd0;
            pix_reg      <= 16'h0000;
            byte_sel_reg <= 1'b0;
            ph_reg       <= 1'b0;
            data_reg     <= 8'h00;
            wck_reg      <= 1'b0;
            we_n_reg     <= 1'b1;
            wrst_n_reg   <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            underrun_reg <= 1'b0;
            ready_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pix_left_reg <= pix_left_next;
            wrst_cnt_reg <= wrst_cnt_next;
            pix_reg      <= pix_next;
            byte_sel_reg <= byte_sel_next;
            ph_reg       <= ph_next;
            data_reg     <= data_next;
            wck_reg      <= wck_next;
            we_n_reg     <= we_n_next;
            wrst_n_reg   <= wrst_n_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            underrun_reg <= underrun_next;
            ready_reg    <= ready_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign fifo_data     = data_reg;
    assign fifo_wck      = wck_reg;
    assign fifo_we_n     = we_n_reg;
    assign fifo_wrst_n   = wrst_n_reg;
    assign busy          = busy_reg;
    assign frame_done    = done_reg;
    assign underrun      = underrun_reg;
    assign pix.pix_ready = ready_reg;

endmodule

// File: doc/al422_frame_writer.md
# al422_frame_writer

Write-side companion of the LED panel receive path: takes RGB555 pixel words from the frame source and writes them into the AL422 field FIFO as two bytes per pixel, low byte first, so the read side reassembles each word in the same order. Each frame begins with a write-pointer reset (WRST) and ends with a `frame_done` strobe. The block generates the FIFO write clock, write-enable and write-reset from the system clock.

## Interface
- `FRAME_PIXELS`, 2048: pixels per frame (64x32 panel); 1..65535.
- `WRST_CYCLES`, 4: `in_clk` cycles `fifo_wrst_n` is held low; must be ≥ 2.

Ports:
- `in_clk`  in  1  system clock; all logic on its rising edge.
- `in_rst`  in  1  reset, synchronous and active-high.
- `frame_start`  in  1  one-cycle request to write a frame; ignored unless idle.
- `pix_data`  in  16  RGB555 word {1'b0, B[4:0], G[4:0], R[4:0]}.
- `pix_valid`  in  1  `pix_data` valid.
- `pix_ready`  out  1  pixel accepted on cycles with `pix_valid & pix_ready`.
- `fifo_data`  out  8  AL422 DI[7:0].
- `fifo_wck`  out  1  AL422 WCK.
- `fifo_we_n`  out  1  AL422 /WE, active-low.
- `fifo_wrst_n`  out  1  AL422 /WRST, active-low.
- `busy`  out  1  high from accepted `frame_start` until `frame_done`.
- `frame_done`  out  1  one-cycle strobe after the last byte's WCK rising edge.
- `underrun`  out  1  sticky pad flag; see Configuration.

## Operation
- States: IDLE, WRST, FETCH, WRITE, DONE.
- Reset values: all outputs registered; `fifo_data`=0, `fifo_wck`=0, `fifo_we_n`=1, `fifo_wrst_n`=1, `busy`=0, `frame_done`=0, `underrun`=0; `pix_ready`=0. Internal counters cleared.
- IDLE: `frame_start`=1 -> WRST; load `pix_left`=`FRAME_PIXELS`, `wrst_cnt`=`WRST_CYCLES`-1, clear `underrun`.
- WRST: `fifo_wrst_n`=0, `fifo_wck` toggles each cycle (AL422 needs WCK during WRST); when `wrst_cnt`=0 -> FETCH.
- FETCH: `pix_ready`=1, `fifo_we_n`=1, `fifo_wck`=0. On handshake: capture word into `pix_reg`, decrement `pix_left`, `byte_sel`=0, `ph`=0 -> WRITE.
- WRITE: 2-cycle byte slot. `ph`=0: `fifo_data`=`pix_reg[7:0]` (`byte_sel`=0) or `pix_reg[15:8]` (`byte_sel`=1), `fifo_wck`=0, `fifo_we_n`=0. `ph`=1: `fifo_wck`=1, data held; AL422 latches on this edge.
- End of high-byte slot (`ph`=1, `byte_sel`=1): `pix_left`>0 -> `pix_ready`=1 on this cycle; if `pix_valid`, load next word and continue WRITE without gap, otherwise -> FETCH. `pix_left`=0 -> DONE.
- DONE: `fifo_we_n`=1, `frame_done`=1 for one cycle -> IDLE; `busy` drops the same cycle.
- `frame_start` outside IDLE is ignored; `pix_valid` is ignored while `pix_ready`=0.
- `in_rst` mid-frame: next edge restores all reset values; the partial frame is abandoned; the next frame's WRST rewinds the FIFO.

## Timing
- `frame_start` at cycle T -> `fifo_wrst_n` low T+1..T+`WRST_CYCLES`.
- First pixel valid in FETCH at cycle F -> first byte on `fifo_data` at F+1, WCK rising at F+2.
- Continuous stream: 4 cycles per pixel, 2 per byte; `fifo_we_n` stays low across pixel boundaries.
- `pix_left` width: 16 bits; it decrements on each accepted pixel and never wraps.
- Minimum frame time: 1 + `WRST_CYCLES` + 1 + 4*`FRAME_PIXELS` + 1 cycles.

## Configuration
- `AL422_WRITER_PAD_EN` undefined: FETCH waits indefinitely for `pix_valid`; `underrun` is tied to 0.
- `AL422_WRITER_PAD_EN` defined: at the end of the high-byte slot, or in FETCH after the first pixel, missing `pix_valid` loads 0x0000 instead of stalling. The padded pixel decrements `pix_left` and sets `underrun`=1 until the next accepted `frame_start`, keeping frame timing fixed. The first pixel of a frame still waits.

## Test plan
- Reset then idle, `FRAME_PIXELS`=4 -> all outputs at reset values, with no WCK edges and no WRST for 20 cycles.
- `frame_start`, continuous pixels 0x1234, 0x5678, 0x7FFF, 0x0001 -> WRST low 4 cycles, then bytes 34,12,78,56,FF,7F,01,00 on successive WCK rises; `frame_done` once; 16 write cycles.
- Stall: `pix_valid` dropped 10 cycles after pixel 2 -> `fifo_we_n` high and WCK low during gap; byte sequence intact.
- `frame_start` pulsed mid-frame -> ignored; byte count and `frame_done` timing unchanged.
- `in_rst` asserted during a second byte -> outputs reset next edge; a new frame writes the full correct sequence after WRST.
- `AL422_WRITER_PAD_EN` defined, source stops after 2 of 4 pixels -> bytes 00,00,00,00 are padded, `underrun`=1, and `frame_done` arrives at the nominal cycle.
